// File: rtl/vga_pkg.sv
// Shared encodings for the frame-pattern source.
// Holds mode/state codes and the colour-bar code ROM.
package vga_pkg;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_GRAD  = 2'd1;
  localparam logic [1:0] MODE_CHECK = 2'd2;
  localparam logic [1:0] MODE_ADDR  = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Entry i holds colour code 7-i; bits are {R,G,B} on/off.
  localparam logic [23:0] BAR_ROM = {
    3'd0, 3'd1, 3'd2, 3'd3,
    3'd4, 3'd5, 3'd6, 3'd7
  };

  function automatic logic [2:0] bar_code(
    input logic [2:0] idx
  );
    return BAR_ROM[idx*3 +: 3];
  endfunction

endpackage

// File: rtl/vga_pattern_pixel.sv
// Combinational pixel function for the pattern source.
// In: mode, x, y, bar, lin, frame_cnt. Out: pix {R,G,B}.
module vga_pattern_pixel
  import vga_pkg::*;
#(
  parameter int XW         = 10,
  parameter int YW         = 10,
  parameter int LW         = 20,
  parameter int R_W        = 5,
  parameter int G_W        = 6,
  parameter int B_W        = 5,
  parameter int BAR_COUNT  = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic [1:0]             mode,
  input  logic [XW-1:0]          x,
  input  logic [YW-1:0]          y,
  input  logic [2:0]             bar,
  input  logic [LW-1:0]          lin,
  input  logic [7:0]             frame_cnt,
  output logic [R_W+G_W+B_W-1:0] pix
);

  localparam int DW    = R_W + G_W + B_W;
  localparam int BSTEP = 8 / BAR_COUNT;
  localparam int EW    = XW + DW;
  localparam int AW    = (LW > DW) ? LW : DW;

  logic [2:0]    code;
  logic [DW-1:0] bar_pix;
  logic [EW-1:0] xe;
  logic [DW-1:0] grad_pix;
  logic [XW-1:0] xs;
  logic [YW-1:0] ys;
  logic [DW-1:0] chk_pix;
  logic [AW-1:0] le;
  logic [DW-1:0] addr_pix;

  // Scale bar index so fewer bars still span the full code range.
  assign code    = bar_code(3'(bar * BSTEP));
  assign bar_pix = {{R_W{code[2]}},
                    {G_W{code[1]}},
                    {B_W{code[0]}}};

  // x is MSB-aligned into each channel; short x pads LSBs with 0.
  assign xe       = {x, {DW{1'b0}}};
  assign grad_pix = {xe[EW-1 -: R_W],
                     xe[EW-1 -: G_W],
                     xe[EW-1 -: B_W]};

  assign xs      = x >> CHECK_LOG2;
  assign ys      = y >> CHECK_LOG2;
  assign chk_pix = {DW{xs[0] ^ ys[0]}};

  assign le       = AW'(lin);
  assign addr_pix = le[DW-1:0] + DW'(frame_cnt);

  always_comb begin
    pix = '0;
    unique case (1'b1)
      (mode == MODE_BARS):  pix = bar_pix;
      (mode == MODE_GRAD):  pix = grad_pix;
      (mode == MODE_CHECK): pix = chk_pix;
      (mode == MODE_ADDR):  pix = addr_pix;
      default:              pix = '0;
    endcase
  end

endmodule

// File: rtl/vga_pattern_gen.sv
// Frame-pattern source: one raster frame per start_i, paced by wr_en.
// In: clk, rst, start_i, mode_i, wr_en. Out: data_en, dout, busy, frame_done, frame_cnt.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = 1024,
  parameter int V_ACTIVE   = 768,
  parameter int R_W        = 5,
  parameter int G_W        = 6,
  parameter int B_W        = 5,
  parameter int DATA_W     = R_W + G_W + B_W,
  parameter int BAR_COUNT  = 8,
  parameter int CHECK_LOG2 = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              wr_en,
  output logic              data_en,
  output logic [DATA_W-1:0] dout,
  output logic              busy,
  output logic              frame_done,
  output logic [7:0]        frame_cnt
);

  localparam int XW  = $clog2(H_ACTIVE);
  localparam int YW  = $clog2(V_ACTIVE);
  localparam int LW  = $clog2(H_ACTIVE * V_ACTIVE);
  localparam int BPX = H_ACTIVE / BAR_COUNT;
  localparam int BW  = (BPX > 1) ? $clog2(BPX) : 1;

  logic [0:0]        state;
  logic [1:0]        mode_q;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [LW-1:0]     lin;
  logic [2:0]        bar;
  logic [BW-1:0]     bar_px;
  logic              x_last;
  logic              y_last;
  logic              last;
  logic [DATA_W-1:0] pix;

  assign x_last = (x == XW'(H_ACTIVE - 1));
  assign y_last = (y == YW'(V_ACTIVE - 1));
  assign last   = x_last && y_last;
  assign busy   = (state == ST_RUN);

  vga_pattern_pixel #(
    .XW        (XW),
    .YW        (YW),
    .LW        (LW),
    .R_W       (R_W),
    .G_W       (G_W),
    .B_W       (B_W),
    .BAR_COUNT (BAR_COUNT),
    .CHECK_LOG2(CHECK_LOG2)
  ) u_pixel (
    .mode     (mode_q),
    .x        (x),
    .y        (y),
    .bar      (bar),
    .lin      (lin),
    .frame_cnt(frame_cnt),
    .pix      (pix)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      mode_q     <= '0;
      x          <= '0;
      y          <= '0;
      lin        <= '0;
      bar        <= '0;
      bar_px     <= '0;
      data_en    <= 1'b0;
      dout       <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      data_en    <= 1'b0;
      frame_done <= 1'b0;
      if (state == ST_IDLE) begin
        if (start_i) begin
          mode_q <= mode_i;
          x      <= '0;
          y      <= '0;
          lin    <= '0;
          bar    <= '0;
          bar_px <= '0;
          state  <= ST_RUN;
        end
      end else if (wr_en) begin
        data_en <= 1'b1;
        dout    <= pix;
        if (last) begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 8'd1;
          x          <= '0;
          y          <= '0;
          lin        <= '0;
          bar        <= '0;
          bar_px     <= '0;
          // A start on the final pixel chains the next frame.
          if (start_i) mode_q <= mode_i;
          else         state  <= ST_IDLE;
        end else if (x_last) begin
          x      <= '0;
          y      <= y + 1'b1;
          lin    <= lin + 1'b1;
          bar    <= '0;
          bar_px <= '0;
        end else begin
          x   <= x + 1'b1;
          lin <= lin + 1'b1;
          if (bar_px == BW'(BPX - 1)) begin
            bar_px <= '0;
            bar    <= bar + 1'b1;
          end else begin
            bar_px <= bar_px + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen at 16x4.
// Driver pushes expected pixels; monitor pops on data_en.
module tb_vga_pattern_gen;

  localparam int H = 16;
  localparam int V = 4;
  localparam int N = H * V;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  mode_i;
  logic        wr_en;
  logic        data_en;
  logic [15:0] dout;
  logic        busy;
  logic        frame_done;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  vga_pattern_gen #(
    .H_ACTIVE  (H),
    .V_ACTIVE  (V),
    .BAR_COUNT (8),
    .CHECK_LOG2(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .mode_i    (mode_i),
    .wr_en     (wr_en),
    .data_en   (data_en),
    .dout      (dout),
    .busy      (busy),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt)
  );

  typedef struct packed {
    logic [15:0] pix;
    logic        done;
    logic [7:0]  fc;
  } exp_t;

  // White, yellow, magenta, red, cyan, green, blue, black.
  localparam logic [15:0] BARS [8] = '{
    16'hFFFF, 16'hFFE0, 16'hF81F, 16'hF800,
    16'h07FF, 16'h07E0, 16'h001F, 16'h0000
  };

  exp_t       q[$];
  exp_t       e;
  int         checks = 0;
  int         errors = 0;
  int         npix   = 0;
  logic [7:0] fc_m   = 8'd0;

  function automatic logic [15:0] exp_pix(
    input logic [1:0] m,
    input int         x,
    input int         y,
    input int         lin,
    input logic [7:0] fc
  );
    int r;
    int g;
    int b;
    case (m)
      2'd0: return BARS[x/2];
      2'd1: begin
        r = (x << 5) >> 4;
        g = (x << 6) >> 4;
        b = (x << 5) >> 4;
        return {r[4:0], g[5:0], b[4:0]};
      end
      2'd2: return (((x/4) + (y/4)) % 2 != 0) ? 16'hFFFF : 16'h0000;
      default: return 16'(lin + int'(fc));
    endcase
  endfunction

  task automatic push(input logic [1:0] m, input int n);
    exp_t t;
    t.pix  = exp_pix(m, n % H, n / H, n, fc_m);
    t.done = (n == N - 1);
    if (t.done) fc_m = fc_m + 8'd1;
    t.fc   = fc_m;
    q.push_back(t);
  endtask

  always @(negedge clk) begin
    if (data_en === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel got dout=%h want none", dout);
      end else begin
        e = q.pop_front();
        if (dout !== e.pix || frame_done !== e.done ||
            frame_cnt !== e.fc) begin
          errors++;
          $display("FAIL pixel#%0d got %h/%b/%0d want %h/%b/%0d",
                   npix, dout, frame_done, frame_cnt,
                   e.pix, e.done, e.fc);
        end
        npix++;
      end
    end else if (rst === 1'b0) begin
      checks++;
      if (frame_done !== 1'b0) begin
        errors++;
        $display("FAIL stray_done got %b want 0", frame_done);
      end
    end
  end

  task automatic run_frame(
    input logic [1:0] m,
    input int         duty,
    input bit         do_start,
    input bit         chain,
    input logic [1:0] nm,
    input int         mid_start,
    input int         stop_after
  );
    int n   = 0;
    int cyc = 0;
    bit w;
    if (do_start) begin
      @(negedge clk);
      start_i = 1'b1;
      mode_i  = m;
      wr_en   = 1'b1;
      @(negedge clk);
      mode_i  = m ^ 2'b01;
    end
    while (n < stop_after && cyc < 2000) begin
      w       = ($urandom_range(99) < duty);
      wr_en   = w;
      start_i = 1'b0;
      if (chain && w && n == N - 1) begin
        start_i = 1'b1;
        mode_i  = nm;
      end
      if (n == mid_start) begin
        start_i = 1'b1;
        mode_i  = 2'd3;
      end
      @(posedge clk);
      if (w) begin
        push(m, n);
        n++;
      end
      cyc++;
      @(negedge clk);
    end
    wr_en   = 1'b0;
    start_i = 1'b0;
    checks++;
    if (n != stop_after) begin
      errors++;
      $display("FAIL frame_timeout got %0d want %0d", n, stop_after);
    end
    if (stop_after == N) begin
      checks++;
      if (busy !== chain) begin
        errors++;
        $display("FAIL busy_end got %b want %b", busy, chain);
      end
    end
  endtask

  task automatic drain(input string name);
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d left want 0", name, q.size());
      q.delete();
    end
  endtask

  initial begin
    rst     = 1'b1;
    start_i = 1'b1;
    wr_en   = 1'b1;
    mode_i  = 2'd0;
    @(posedge clk);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({data_en, busy, frame_done} !== 3'b000 ||
          frame_cnt !== 8'd0 || dout !== 16'h0) begin
        errors++;
        $display("FAIL reset_state got %b%b%b %0d %h want 0",
                 data_en, busy, frame_done, frame_cnt, dout);
      end
    end
    rst     = 1'b0;
    start_i = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (data_en !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset got %b%b want 00",
                 data_en, busy);
      end
    end
    wr_en = 1'b0;

    run_frame(2'd3, 100, 1, 0, 2'd0, -1, N);
    drain("addr1");
    run_frame(2'd3, 100, 1, 0, 2'd0, -1, N);
    drain("addr2");

    npix = 0;
    run_frame(2'd0, 100, 1, 0, 2'd0, -1, N);
    drain("bars");
    checks++;
    if (npix != N) begin
      errors++;
      $display("FAIL bars_count got %0d want %0d", npix, N);
    end

    run_frame(2'd2, 30, 1, 0, 2'd0, -1, N);
    drain("checker");

    run_frame(2'd2, 100, 1, 1, 2'd1, -1, N);
    run_frame(2'd1, 100, 0, 0, 2'd0, -1, N);
    drain("chain");

    run_frame(2'd1, 100, 1, 0, 2'd0, 10, 20);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (frame_cnt !== 8'd0 || frame_done !== 1'b0 ||
        busy !== 1'b0 || data_en !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got %0d/%b/%b/%b want 0/0/0/0",
               frame_cnt, frame_done, busy, data_en);
    end
    fc_m = 8'd0;
    rst  = 1'b0;
    drain("mid_reset");
    run_frame(2'd3, 100, 1, 0, 2'd0, -1, N);
    drain("after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
